seg7_scan_ctrl: RTL

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Binary-to-BCD (serial double-dabble) converter driving a multiplexed, active-low 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG7_LEAD_BLANK_EN.
module seg7_scan_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WIDTH-1:0]  value,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    val_q, val_d;
  logic [BW-1:0]       bcd_q, bcd_d, adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                oflag_q, oflag_d;
  logic [BW-1:0]       disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [3:0]          nib;
  logic                blank_sel;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0011000;
      default: enc = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    oflag_d = oflag_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    adj     = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (load) begin
          val_d   = value;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          oflag_d = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d   = {adj[BW-2:0], val_q[WIDTH-1]};
        val_d   = val_q << 1;
        cnt_d   = cnt_q - CW'(1);
        // A set bit leaving the top nibble means the value needs more digits than exist.
        oflag_d = oflag_q | adj[BW-1];
        if (cnt_q == CW'(1)) begin
          disp_d  = bcd_d;
          ovf_d   = oflag_d;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    nib       = 4'd0;
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) nib = disp_q[i*4 +: 4];
    end
`ifdef SEG7_LEAD_BLANK_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
        zero_above = zero_above & (disp_q[i*4 +: 4] == 4'd0);
        if ((idx_q == IW'(i)) && zero_above) blank_sel = 1'b1;
      end
    end
`endif
    if (ovf_q)          seg_d = SEG_DASH;
    else if (blank_sel) seg_d = SEG_BLANK;
    else                seg_d = enc(nib);
    for (int i = 0; i < DIGITS; i++) begin
      an_d[i] = (idx_q != IW'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      oflag_q <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= 7'b1000000;
      an_q    <= ~DIGITS'(1);
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      oflag_q <= oflag_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign busy = (state_q == CONV);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule
